// File: rtl/mem_handle_responder_if.sv
// mem_handle bus between NPORTS initiators and the memory-side responder.
// Per-port fields are packed side by side, port p occupying slice [p*W +: W].
interface mem_handle_responder_if #(
    parameter int NPORTS = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();
    logic [NPORTS-1:0]        avail;
    logic [NPORTS-1:0]        r_en;
    logic [NPORTS-1:0]        w_en;
    logic [NPORTS*ADDR_W-1:0] ptr;
    logic [NPORTS*DATA_W-1:0] data_store;
    logic [NPORTS*DATA_W-1:0] data_load;
    logic [NPORTS-1:0]        done;

    modport master (output avail, r_en, w_en, ptr, data_store,
                    input  data_load, done);
    modport slave  (input  avail, r_en, w_en, ptr, data_store,
                    output data_load, done);
endinterface

// File: rtl/mem_handle_responder.sv
// Memory-side responder of the mem_handle protocol: round-robin arbitration of
// NPORTS initiators onto one single-ported synchronous SRAM, one access at a time.
module mem_handle_responder #(
    parameter int NPORTS = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_handle_responder_if.slave bus,
    output logic                 sram_en_o,
    output logic                 sram_we_o,
    output logic [ADDR_W-1:0]    sram_addr_o,
    output logic [DATA_W-1:0]    sram_wdata_o,
    input  logic [DATA_W-1:0]    sram_rdata_i,
    output logic                 err_o
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, ACK} state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            rr_q, rr_d, gnt_q, gnt_d, pick;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic [NPORTS-1:0]        mask_q, elig, done_w;
    logic [NPORTS*DATA_W-1:0] dload_q;
    logic                     found, grant, capture;
    logic                     rd_q, wr_q, legal_rd, legal_wr;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        wdata_q;

    assign legal_rd = rd_q & ~wr_q;
    assign legal_wr = wr_q & ~rd_q;

    // A port acked last cycle sits out one cycle so the others get a look in.
    always_comb begin
        elig  = bus.avail & ~mask_q;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && elig[(int'(rr_q) + i) % NPORTS]) begin
                found = 1'b1;
                pick  = PW'((int'(rr_q) + i) % NPORTS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        grant   = 1'b0;
        capture = 1'b0;
        done_w  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    gnt_d   = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (legal_rd) begin
                    cnt_d   = CW'(RD_LAT);
                    state_d = WAIT_RD;
                end else begin
                    if (!legal_wr) err_d = 1'b1;
                    state_d = ACK;
                end
            end
            WAIT_RD: begin
                if (cnt_q == CW'(1)) begin
                    capture = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACK: begin
                done_w[gnt_q] = 1'b1;
                rr_d    = (int'(gnt_q) == NPORTS - 1) ? '0 : gnt_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= done_w;
            if (capture) dload_q[int'(gnt_q)*DATA_W +: DATA_W] <= sram_rdata_i;
        end
    end

    // Request fields are frozen at grant; later initiator changes are ignored.
    always_ff @(posedge clk) begin
        if (grant) begin
            addr_q  <= bus.ptr[int'(pick)*ADDR_W +: ADDR_W];
            wdata_q <= bus.data_store[int'(pick)*DATA_W +: DATA_W];
            rd_q    <= bus.r_en[pick];
            wr_q    <= bus.w_en[pick];
        end
    end

    assign sram_en_o     = (state_q == ISSUE) & (legal_rd | legal_wr);
    assign sram_we_o     = (state_q == ISSUE) & legal_wr;
    assign sram_addr_o   = sram_en_o ? addr_q : '0;
    assign sram_wdata_o  = sram_we_o ? wdata_q : '0;
    assign err_o         = err_q;
    assign bus.done      = done_w;
    assign bus.data_load = dload_q;
endmodule

// File: tb/tb_mem_handle_responder.sv
// Directed bench for mem_handle_responder: one instance with RD_LAT=1, one with RD_LAT=3,
// each backed by a small behavioural SRAM.
module tb_mem_handle_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    mem_handle_responder_if #(.NPORTS(4), .ADDR_W(16), .DATA_W(32)) bus_a ();
    mem_handle_responder_if #(.NPORTS(4), .ADDR_W(16), .DATA_W(32)) bus_b ();

    logic        a_en, a_we, a_err, b_en, b_we, b_err;
    logic [15:0] a_addr, b_addr;
    logic [31:0] a_wdata, a_rdata, b_wdata, b_rdata;

    mem_handle_responder #(.NPORTS(4), .ADDR_W(16), .DATA_W(32), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .sram_en_o(a_en), .sram_we_o(a_we), .sram_addr_o(a_addr),
        .sram_wdata_o(a_wdata), .sram_rdata_i(a_rdata), .err_o(a_err));

    mem_handle_responder #(.NPORTS(4), .ADDR_W(16), .DATA_W(32), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .sram_en_o(b_en), .sram_we_o(b_we), .sram_addr_o(b_addr),
        .sram_wdata_o(b_wdata), .sram_rdata_i(b_rdata), .err_o(b_err));

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] b_p0, b_p1, b_p2;

    always @(posedge clk) begin
        if (pre_en) begin
            mem_a[pre_addr] <= pre_data;
            mem_b[pre_addr] <= pre_data;
        end else begin
            if (a_en && a_we) mem_a[a_addr[7:0]] <= a_wdata;
            if (b_en && b_we) mem_b[b_addr[7:0]] <= b_wdata;
        end
        if (a_en && !a_we) a_rdata <= mem_a[a_addr[7:0]];
        if (b_en && !b_we) b_p0 <= mem_b[b_addr[7:0]];
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_rdata = b_p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pre(input logic [7:0] addr, input logic [31:0] data);
        pre_addr = addr;
        pre_data = data;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic clr_a();
        bus_a.avail = '0; bus_a.r_en = '0; bus_a.w_en = '0;
    endtask

    task automatic clr_b();
        bus_b.avail = '0; bus_b.r_en = '0; bus_b.w_en = '0;
    endtask

    task automatic req_a(input int p, input logic r, input logic w,
                         input logic [15:0] ptr, input logic [31:0] data);
        bus_a.avail[p] = 1'b1;
        bus_a.r_en[p]  = r;
        bus_a.w_en[p]  = w;
        bus_a.ptr[p*16 +: 16]        = ptr;
        bus_a.data_store[p*32 +: 32] = data;
    endtask

    task automatic req_b(input int p, input logic [15:0] ptr);
        bus_b.avail[p] = 1'b1;
        bus_b.r_en[p]  = 1'b1;
        bus_b.w_en[p]  = 1'b0;
        bus_b.ptr[p*16 +: 16] = ptr;
    endtask

    int          n, multi, lat;
    int          g [5];
    logic [3:0]  first;

    initial begin
        rst = 1'b1;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        clr_a(); clr_b();
        bus_a.ptr = '0; bus_a.data_store = '0;
        bus_b.ptr = '0; bus_b.data_store = '0;
        tick(); tick();

        chk("rst_done_a", bus_a.done, 4'h0);
        chk("rst_sram_en_a", a_en, 1'b0);
        chk("rst_err_a", a_err, 1'b0);
        chk("rst_dload_a", bus_a.data_load, 128'h0);
        chk("rst_done_b", bus_b.done, 4'h0);

        pre(8'h10, 32'hDEADBEEF);
        pre(8'h20, 32'hAAAA0020);
        pre(8'h30, 32'hBBBB0030);
        pre(8'h05, 32'h55550005);
        for (int i = 0; i < 4; i++) pre(8'(8'h40 + i), 32'h40000000 + 32'(i));
        rst = 1'b0;
        tick();

        // single read, port 0; avail dropped after grant must not abort it
        req_a(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        tick();
        chk("rd_sram_en", a_en, 1'b1);
        chk("rd_sram_we", a_we, 1'b0);
        chk("rd_sram_addr", a_addr, 16'h0010);
        clr_a();
        tick();
        chk("rd_done_c2", bus_a.done, 4'h0);
        tick();
        chk("rd_done_c3", bus_a.done, 4'h1);
        chk("rd_dload0", bus_a.data_load[31:0], 32'hDEADBEEF);
        tick();
        chk("rd_done_c4", bus_a.done, 4'h0);
        tick();

        // write on port 3, then read it back
        req_a(3, 1'b0, 1'b1, 16'h0004, 32'h12345678);
        tick();
        chk("wr_sram_en", a_en, 1'b1);
        chk("wr_sram_we", a_we, 1'b1);
        chk("wr_sram_addr", a_addr, 16'h0004);
        chk("wr_sram_wdata", a_wdata, 32'h12345678);
        clr_a();
        tick();
        chk("wr_done_c2", bus_a.done, 4'h8);
        tick(); tick();
        req_a(3, 1'b1, 1'b0, 16'h0004, 32'h0);
        tick();
        clr_a();
        tick(); tick();
        chk("rb_done", bus_a.done, 4'h8);
        chk("rb_dload3", bus_a.data_load[127:96], 32'h12345678);
        chk("rb_dload0_kept", bus_a.data_load[31:0], 32'hDEADBEEF);
        tick(); tick();

        // request fields change after grant
        req_a(0, 1'b1, 1'b0, 16'h0020, 32'h0);
        tick();
        bus_a.ptr[15:0] = 16'h0030;
        chk("latch_addr", a_addr, 16'h0020);
        tick();
        clr_a();
        tick();
        chk("latch_dload0", bus_a.data_load[31:0], 32'hAAAA0020);
        tick(); tick();

        // illegal request on port 1
        req_a(1, 1'b1, 1'b1, 16'h0010, 32'h0);
        tick();
        chk("ill_sram_en", a_en, 1'b0);
        chk("ill_err_c1", a_err, 1'b0);
        clr_a();
        tick();
        chk("ill_done", bus_a.done, 4'h2);
        chk("ill_err_c2", a_err, 1'b1);
        tick(); tick(); tick();
        chk("ill_err_sticky", a_err, 1'b1);

        // round robin from rr=0, all ports reading continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rr_err_cleared", a_err, 1'b0);
        for (int p = 0; p < 4; p++) req_a(p, 1'b1, 1'b0, 16'(16'h0040 + p), 32'h0);
        n = 0; multi = 0;
        for (int i = 0; i < 5; i++) g[i] = 9;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (bus_a.done != 4'h0) begin
                if ($countones(bus_a.done) != 1) multi++;
                for (int k = 0; k < 4; k++) if (bus_a.done[k]) g[n] = k;
                n++;
            end
        end
        clr_a();
        chk("rr_grants", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(g[i]), 32'(i % 4));
        chk("rr_onehot", 32'(multi), 32'd0);
        chk("rr_dload", bus_a.data_load,
            {32'h40000003, 32'h40000002, 32'h40000001, 32'h40000000});
        tick(); tick(); tick(); tick();

        // RD_LAT=3: complete read on port 2 moves rr to 3
        req_b(2, 16'h0005);
        tick();
        clr_b();
        tick(); tick(); tick(); tick();
        chk("b_rd_done_c5", bus_b.done, 4'h4);
        chk("b_rd_dload2", bus_b.data_load[95:64], 32'h55550005);
        tick(); tick();

        // reset while port 0 read sits in WAIT_RD
        req_b(0, 16'h0010);
        tick();
        clr_b();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_done", bus_b.done, 4'h0);
        chk("mid_rst_sram_en", b_en, 1'b0);
        chk("mid_rst_err", b_err, 1'b0);
        chk("mid_rst_dload", bus_b.data_load, 128'h0);
        tick();
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus_b.done != 4'h0) n++;
        end
        chk("mid_rst_no_done", 32'(n), 32'd0);
        chk("mid_rst_dload0", bus_b.data_load[31:0], 32'h0);

        // fresh requests on ports 2 and 3: rr=0 scan must pick port 2 first
        req_b(2, 16'h0005);
        req_b(3, 16'h0010);
        first = '0; lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus_b.done != 4'h0) begin
                first = bus_b.done;
                lat = c;
                break;
            end
        end
        clr_b();
        chk("fresh_first_port", first, 4'h4);
        chk("fresh_latency", 32'(lat), 32'd5);
        chk("fresh_dload2", bus_b.data_load[95:64], 32'h55550005);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
